// File: rtl/regfile_wb.sv
// Architectural register file fed by the MEM/WB write-back triple, with two
// write-through read ports, a registered commit trace and a saturating commit counter.
module regfile_wb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              trace_valid,
    output logic [ADDR_W-1:0] trace_addr,
    output logic [DATA_W-1:0] trace_data,
    output logic [31:0]       commit_cnt
);
    localparam int unsigned NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic              commit;

    // A write to r0, a disabled write or a write under reset is a bubble.
    assign commit = we && (waddr != '0) && !rst;

    // Read ports: zero under reset/disable/r0, otherwise bypass the in-flight write.
    always_comb begin
        rdata1 = '0;
        if (!rst && re1 && (raddr1 != '0)) begin
            rdata1 = (commit && (raddr1 == waddr)) ? wdata : regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (!rst && re2 && (raddr2 != '0)) begin
            rdata2 = (commit && (raddr2 == waddr)) ? wdata : regs[raddr2];
        end
    end

    // Storage, trace and counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            trace_valid <= 1'b0;
            trace_addr  <= '0;
            trace_data  <= '0;
            commit_cnt  <= '0;
        end else begin
            trace_valid <= commit;
            if (commit) begin
                regs[waddr] <= wdata;
                trace_addr  <= waddr;
                trace_data  <= wdata;
                if (commit_cnt != 32'hFFFF_FFFF) begin
                    commit_cnt <= commit_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed and randomized check of regfile_wb against an array-based model of
// the architectural register state, trace and commit count.
module tb_regfile_wb;
    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        trace_valid;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic [31:0] commit_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [31:0] mregs [32];
    logic [31:0] mcnt;
    logic        mtv;
    logic [4:0]  mta;
    logic [31:0] mtd;

    regfile_wb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .trace_valid(trace_valid), .trace_addr(trace_addr),
        .trace_data(trace_data), .commit_cnt(commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic e, input logic [4:0] a);
        logic cm;
        cm = we && (waddr != 0) && !rst;
        if (rst || !e || a == 0) return 32'd0;
        if (cm && a == waddr) return wdata;
        return mregs[a];
    endfunction

    // One clock cycle: drive, check reads mid-cycle, clock, update model, check state.
    task automatic cyc(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
        logic cm;
        @(negedge clk);
        rst = r; we = w; waddr = wa; wdata = wd;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
        #1;
        chk("rdata1", rdata1, model_read(e1, a1));
        chk("rdata2", rdata2, model_read(e2, a2));
        cm = w && (wa != 0) && !r;
        @(posedge clk);
        if (r) begin
            foreach (mregs[i]) mregs[i] = 32'd0;
            mcnt = 32'd0; mtv = 1'b0; mta = 5'd0; mtd = 32'd0;
        end else begin
            mtv = cm;
            if (cm) begin
                mregs[wa] = wd;
                mta = wa;
                mtd = wd;
                if (mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 32'd1;
            end
        end
        #1;
        chk("trace_valid", 32'(trace_valid), 32'(mtv));
        chk("trace_addr", 32'(trace_addr), 32'(mta));
        chk("trace_data", trace_data, mtd);
        chk("commit_cnt", commit_cnt, mcnt);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'd0;
        re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
        foreach (mregs[i]) mregs[i] = 32'd0;
        mcnt = 32'd0; mtv = 1'b0; mta = 5'd0; mtd = 32'd0;

        // Reset, then sweep all addresses on both ports
        cyc(1, 0, 0, 0, 1, 5, 1, 7);
        cyc(1, 0, 0, 0, 1, 1, 1, 2);
        for (int i = 0; i < 32; i++) cyc(0, 0, 0, 0, 1, 5'(i), 1, 5'(31 - i));
        chk("reset_cnt_const", commit_cnt, 32'd0);

        // r5 write with same-cycle bypass, then storage read
        cyc(0, 1, 5, 32'hDEAD_BEEF, 1, 5, 0, 0);
        chk("bypass_r5", rdata1, 32'hDEAD_BEEF);
        cyc(0, 0, 0, 0, 1, 5, 1, 5);
        chk("stored_r5", rdata1, 32'hDEAD_BEEF);

        // r0 write is dropped
        cyc(0, 1, 0, 32'h1234_5678, 1, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0, 1, 0);

        // Back-to-back commits with bypass on both ports
        cyc(0, 1, 3, 32'd1, 1, 3, 1, 7);
        cyc(0, 1, 3, 32'd2, 1, 3, 1, 7);
        cyc(0, 1, 7, 32'd3, 1, 3, 1, 7);
        cyc(0, 0, 0, 0, 1, 3, 1, 7);
        chk("final_r3", rdata1, 32'd2);
        chk("final_r7", rdata2, 32'd3);
        chk("b2b_cnt", commit_cnt, 32'd4);

        // Disabled read port and a bubble targeting r9
        cyc(0, 0, 9, 32'hFF, 1, 9, 0, 3);
        cyc(0, 0, 0, 0, 1, 9, 1, 3);

        // Write under reset is discarded
        cyc(1, 1, 4, 32'hAAAA, 1, 4, 1, 4);
        cyc(0, 0, 0, 0, 1, 4, 1, 5);
        chk("post_rst_cnt", commit_cnt, 32'd0);

        // Saturation from a deposited near-max count
        @(negedge clk);
        dut.commit_cnt = 32'hFFFF_FFFE;
        mcnt = 32'hFFFF_FFFE;
        cyc(0, 1, 1, 32'h11, 1, 1, 1, 2);
        cyc(0, 1, 2, 32'h22, 1, 1, 1, 2);
        cyc(0, 1, 3, 32'h33, 1, 3, 1, 2);
        chk("saturated", commit_cnt, 32'hFFFF_FFFF);
        // Reset beats saturation
        cyc(1, 1, 6, 32'h66, 1, 6, 1, 6);

        // Randomized traffic, addresses biased toward a small set for bypass hits
        for (int n = 0; n < 400; n++) begin
            logic       r, w, e1, e2;
            logic [4:0] wa, a1, a2;
            r  = ($urandom_range(0, 39) == 0);
            w  = ($urandom_range(0, 3) != 0);
            wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            e1 = ($urandom_range(0, 4) != 0);
            e2 = ($urandom_range(0, 4) != 0);
            cyc(r, w, wa, $urandom, e1, a1, e2, a2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
